cl_tptn_chk: RTL and testbench

Receive-side checker for the Camera Link style test-pattern stream. It consumes the `{dval, fval, lval, data}` dot bus driven by the test-pattern generator and measures frame geometry: pixels per line and lines per frame. It also verifies the alternating A/B pixel pattern and reports per-frame results and sticky error flags. It sits on the receive side of the loopback path as the self-test sink for the link.

---
 rtl/cl_tptn_chk.sv | 204 ++++++++++++++++++++
 tb/tb_cl_tptn_chk.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_tptn_chk.sv
// Receive-side checker for the Camera Link test-pattern dot bus: measures line and frame
// geometry, verifies the alternating A/B pixel pattern and keeps sticky error flags.
module cl_tptn_chk #(
    parameter int unsigned DW     = 24,
    parameter int unsigned L_LEN  = 32,
    parameter int unsigned H_LEN  = 24,
    parameter logic [9:0]  TPTN_A = 10'h155,
    parameter logic [9:0]  TPTN_B = 10'h2aa
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          en,
    input  logic          clr,
    input  logic [DW+2:0] dot,
    output logic          frame_done,
    output logic [15:0]   meas_llen,
    output logic [15:0]   meas_lines,
    output logic [15:0]   frame_cnt,
    output logic [15:0]   ptn_err_cnt,
    output logic          llen_err,
    output logic          lines_err,
    output logic          ptn_err,
    output logic          proto_err,
    output logic          locked
);

    localparam logic [DW-1:0] PAT_A = {{(DW-10){1'b1}}, TPTN_A};
    localparam logic [DW-1:0] PAT_B = {{(DW-10){1'b1}}, TPTN_B};
    localparam logic [15:0]   SAT   = 16'hFFFF;

    typedef enum logic [1:0] {StSync, StWaitFv, StInFrame, StClose} state_t;

    state_t        state_q, state_d;
    logic [DW+2:0] s1_q;
    logic          fv2_q, lv2_q;
    logic          primed_q;
    logic [15:0]   line_cnt_q, pix_cnt_q, pix_sum, llen_cap_q;
    logic          exp_b_q, exp_b_d, phase_vld_q, phase_vld_d;
    logic          line_end_q, mism_q;
    logic          frame_start, active, line_rise, line_end, pix_vld, mism, proto_hit;
    logic          dv1, fv1, lv1;
    logic [DW-1:0] pix, exp_word, alt_word;

    assign dv1 = s1_q[DW+2];
    assign fv1 = s1_q[DW+1];
    assign lv1 = s1_q[DW];
    assign pix = s1_q[DW-1:0];

    // primed_q marks s1 as holding real bus data, so SYNC never mistakes the reset value
    // of s1 for a frame gap and lock onto the tail of an interrupted frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q     <= '0;
            fv2_q    <= 1'b0;
            lv2_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            s1_q     <= dot;
            fv2_q    <= fv1;
            lv2_q    <= lv1;
            primed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        unique case (state_q)
            StSync:    if (primed_q && !fv1) state_d = StWaitFv;
            StWaitFv:  if (fv1 && !fv2_q) begin
                state_d     = StInFrame;
                frame_start = 1'b1;
            end
            StInFrame: if (!fv1 && fv2_q) state_d = StClose;
            StClose:   if (fv1 && !fv2_q) begin
                state_d     = StInFrame;
                frame_start = 1'b1;
            end else begin
                state_d = StWaitFv;
            end
            default:   state_d = StSync;
        endcase
        if (!en) begin
            state_d     = StSync;
            frame_start = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= StSync;
        else     state_q <= state_d;
    end

    assign active    = frame_start | (en && state_q == StInFrame);
    assign line_rise = active & fv1 & lv1 & ~lv2_q;
    // fval dropping under a high lval closes the line in the same cycle
    assign line_end  = en && state_q == StInFrame && lv2_q && (!lv1 || !fv1);
    assign pix_vld   = active & dv1;
    assign pix_sum   = (pix_vld && pix_cnt_q != SAT) ? pix_cnt_q + 16'd1 : pix_cnt_q;
    assign proto_hit = (state_q != StSync) && ((lv1 && !fv1) || (dv1 && !lv1));
    assign locked    = (state_q == StWaitFv) || (state_q == StInFrame);

    assign exp_word = exp_b_q ? PAT_B : PAT_A;
    assign alt_word = exp_b_q ? PAT_A : PAT_B;

    // exp_b_q selects the word expected on the next pixel; a slip re-phases onto the
    // received word, which leaves the expectation for the following pixel unchanged.
    always_comb begin
        exp_b_d     = exp_b_q;
        phase_vld_d = phase_vld_q & ~frame_start;
        mism        = 1'b0;
        if (pix_vld) begin
            phase_vld_d = 1'b1;
            if (!phase_vld_q || frame_start) begin
                if (pix == PAT_A) begin
                    exp_b_d = 1'b1;
                end else if (pix == PAT_B) begin
                    exp_b_d = 1'b0;
                end else begin
                    mism    = 1'b1;
                    exp_b_d = 1'b0;
                end
            end else if (pix == exp_word) begin
                exp_b_d = ~exp_b_q;
            end else begin
                mism = 1'b1;
                if (pix != alt_word) exp_b_d = ~exp_b_q;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            line_cnt_q  <= '0;
            pix_cnt_q   <= '0;
            llen_cap_q  <= '0;
            line_end_q  <= 1'b0;
            mism_q      <= 1'b0;
            exp_b_q     <= 1'b0;
            phase_vld_q <= 1'b0;
        end else begin
            exp_b_q     <= exp_b_d;
            phase_vld_q <= phase_vld_d;
            line_end_q  <= line_end;
            mism_q      <= mism;
            if (frame_start) begin
                line_cnt_q <= {15'd0, line_rise};
            end else if (line_rise && line_cnt_q != SAT) begin
                line_cnt_q <= line_cnt_q + 16'd1;
            end
            if (line_end) begin
                llen_cap_q <= pix_sum;
                pix_cnt_q  <= '0;
            end else if (frame_start) begin
                pix_cnt_q <= {15'd0, pix_vld};
            end else begin
                pix_cnt_q <= pix_sum;
            end
        end
    end

    // Later assignments override the clear so that a coincident set or load wins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_done  <= 1'b0;
            meas_llen   <= '0;
            meas_lines  <= '0;
            frame_cnt   <= '0;
            ptn_err_cnt <= '0;
            llen_err    <= 1'b0;
            lines_err   <= 1'b0;
            ptn_err     <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            frame_done <= (state_q == StClose);
            if (clr) begin
                meas_llen   <= '0;
                meas_lines  <= '0;
                frame_cnt   <= '0;
                ptn_err_cnt <= '0;
                llen_err    <= 1'b0;
                lines_err   <= 1'b0;
                ptn_err     <= 1'b0;
                proto_err   <= 1'b0;
            end
            if (line_end_q) begin
                meas_llen <= llen_cap_q;
                if (llen_cap_q != 16'(L_LEN)) llen_err <= 1'b1;
            end
            if (state_q == StClose) begin
                meas_lines <= line_cnt_q;
                frame_cnt  <= (clr ? 16'd0 : frame_cnt) + 16'd1;
                if (line_cnt_q != 16'(H_LEN)) lines_err <= 1'b1;
            end
            if (mism_q) begin
                ptn_err <= 1'b1;
                if (clr)                     ptn_err_cnt <= 16'd1;
                else if (ptn_err_cnt != SAT) ptn_err_cnt <= ptn_err_cnt + 16'd1;
            end
            if (proto_hit) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cl_tptn_chk.sv
// Self-checking bench for cl_tptn_chk: randomized frame generator driving the dot bus on
// the falling edge, with a frame-level reference model of geometry and pattern errors.
module tb_cl_tptn_chk;

    localparam int DW    = 24;
    localparam int L_LEN = 32;
    localparam int H_LEN = 24;
    localparam logic [DW-1:0] PA = {{(DW-10){1'b1}}, 10'h155};
    localparam logic [DW-1:0] PB = {{(DW-10){1'b1}}, 10'h2aa};

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          en  = 1'b0;
    logic          clr = 1'b0;
    logic [DW+2:0] dot = '0;
    logic          frame_done, llen_err, lines_err, ptn_err, proto_err, locked;
    logic [15:0]   meas_llen, meas_lines, frame_cnt, ptn_err_cnt;

    cl_tptn_chk #(
        .DW     (DW),
        .L_LEN  (L_LEN),
        .H_LEN  (H_LEN),
        .TPTN_A (10'h155),
        .TPTN_B (10'h2aa)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .en          (en),
        .clr         (clr),
        .dot         (dot),
        .frame_done  (frame_done),
        .meas_llen   (meas_llen),
        .meas_lines  (meas_lines),
        .frame_cnt   (frame_cnt),
        .ptn_err_cnt (ptn_err_cnt),
        .llen_err    (llen_err),
        .lines_err   (lines_err),
        .ptn_err     (ptn_err),
        .proto_err   (proto_err),
        .locked      (locked)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // Reference model state
    int          exp_frames, exp_pulses, exp_llen, exp_lines, exp_pcnt;
    bit          exp_llen_err, exp_lines_err, exp_ptn_err, exp_proto_err;
    bit          m_first;
    logic [DW-1:0] m_exp;
    int          m_errs;

    always @(negedge CLK or posedge RST) begin
        if (RST)             pulses <= 0;
        else if (frame_done) pulses <= pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string sc);
        check_eq({sc, "/frame_cnt"},   32'(frame_cnt),   32'(exp_frames & 16'hFFFF));
        check_eq({sc, "/pulses"},      32'(pulses),      32'(exp_pulses));
        check_eq({sc, "/meas_llen"},   32'(meas_llen),   32'(exp_llen));
        check_eq({sc, "/meas_lines"},  32'(meas_lines),  32'(exp_lines));
        check_eq({sc, "/ptn_err_cnt"}, 32'(ptn_err_cnt), 32'(exp_pcnt));
        check_eq({sc, "/llen_err"},    32'(llen_err),    32'(exp_llen_err));
        check_eq({sc, "/lines_err"},   32'(lines_err),   32'(exp_lines_err));
        check_eq({sc, "/ptn_err"},     32'(ptn_err),     32'(exp_ptn_err));
        check_eq({sc, "/proto_err"},   32'(proto_err),   32'(exp_proto_err));
    endtask

    task automatic model_zero();
        exp_frames = 0; exp_llen = 0; exp_lines = 0; exp_pcnt = 0;
        exp_llen_err = 0; exp_lines_err = 0; exp_ptn_err = 0; exp_proto_err = 0;
    endtask

    function automatic logic [DW-1:0] other(input logic [DW-1:0] w);
        return (w == PA) ? PB : PA;
    endfunction

    // Pattern rule applied word by word: first word of a frame sets the phase, later words
    // must alternate; a word equal to the other pattern is taken as a slip.
    task automatic model_pixel(input logic [DW-1:0] w);
        if (m_first) begin
            if (w == PA)      m_exp = PB;
            else if (w == PB) m_exp = PA;
            else begin m_errs++; m_exp = PA; end
            m_first = 0;
        end else if (w == m_exp) begin
            m_exp = other(m_exp);
        end else begin
            m_errs++;
            if (w != other(m_exp)) m_exp = other(m_exp);
        end
    endtask

    task automatic drive(input bit dv, input bit fv, input bit lv, input logic [DW-1:0] d);
        @(negedge CLK);
        dot = {dv, fv, lv, d};
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, '0);
    endtask

    task automatic pulse_clr();
        @(negedge CLK);
        clr = 1'b1;
        @(negedge CLK);
        clr = 1'b0;
        model_zero();
    endtask

    task automatic send_frame(input int nlines, input int short_line, input int bad_line,
                              input int bad_pix, input logic [DW-1:0] bad_val,
                              input int slip_line, input int slip_pix, input int rst_line,
                              input int gap);
        bit            counted = en;
        bit            ph = 0;
        bit            bad_len = 0;
        int            npix = 0;
        logic [DW-1:0] w;
        m_first = 1;
        m_errs  = 0;
        repeat (2) drive(0, 1, 0, '0);
        for (int l = 0; l < nlines; l++) begin
            npix = (l == short_line) ? L_LEN - 1 : L_LEN;
            for (int p = 0; p < npix; p++) begin
                if (l == rst_line && p == 10) begin
                    RST = 1'b1;
                    #1;
                    model_zero();
                    exp_pulses = 0;
                    counted    = 0;
                    check_state("midrst");
                    check_eq("midrst/locked", 32'(locked), 32'(0));
                    check_eq("midrst/frame_done", 32'(frame_done), 32'(0));
                    @(negedge CLK);
                    RST = 1'b0;
                end
                if ($urandom_range(7) == 0) drive(0, 1, 1, '0);
                if (l == slip_line && p == slip_pix) ph = ~ph;
                w = ph ? PB : PA;
                if (l == bad_line && p == bad_pix) w = bad_val;
                drive(1, 1, 1, w);
                ph = ~ph;
                model_pixel(w);
            end
            if (npix != L_LEN) bad_len = 1;
            // the last line sometimes ends with lval and fval falling together
            if (l != nlines - 1 || $urandom_range(1) == 0)
                repeat ($urandom_range(3, 1)) drive(0, 1, 0, '0);
        end
        repeat (gap) drive(0, 0, 0, '0);
        if (counted) begin
            exp_frames++;
            exp_pulses++;
            exp_lines = nlines;
            exp_llen  = npix;
            exp_pcnt += m_errs;
            if (m_errs != 0)      exp_ptn_err = 1;
            if (bad_len)          exp_llen_err = 1;
            if (nlines != H_LEN)  exp_lines_err = 1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0]   r;
        logic [DW-1:0] bv;
        int nl, sl, bl, sll;
        model_zero();
        exp_pulses = 0;
        repeat (3) @(negedge CLK);
        check_state("reset");
        check_eq("reset/locked", 32'(locked), 32'(0));
        check_eq("reset/frame_done", 32'(frame_done), 32'(0));
        RST = 1'b0;
        en  = 1'b1;
        idle(4);
        check_eq("idle/locked", 32'(locked), 32'(1));

        for (int i = 0; i < 3; i++)
            send_frame(H_LEN, -1, -1, -1, '0, -1, -1, -1, $urandom_range(5, 1));
        idle(6);
        check_state("clean");
        check_eq("clean/locked", 32'(locked), 32'(1));

        pulse_clr();
        send_frame(H_LEN, -1, 4, 7, '0, -1, -1, -1, 4);
        idle(6);
        check_state("corrupt");

        pulse_clr();
        send_frame(H_LEN, -1, -1, -1, '0, 3, 5, -1, 4);
        idle(6);
        check_state("slip");

        pulse_clr();
        send_frame(H_LEN, 5, -1, -1, '0, -1, -1, -1, 4);
        idle(6);
        check_state("short");

        pulse_clr();
        send_frame(10, -1, -1, -1, '0, -1, -1, -1, 4);
        idle(6);
        check_state("trunc");
        send_frame(H_LEN, -1, -1, -1, '0, -1, -1, -1, 4);
        idle(6);
        check_state("trunc_full");
        pulse_clr();
        idle(2);
        check_state("trunc_clr");

        // back-to-back frames with random geometry and pattern faults
        for (int i = 0; i < 6; i++) begin
            nl  = ($urandom_range(1) == 0) ? H_LEN : int'($urandom_range(H_LEN, 8));
            sl  = ($urandom_range(2) == 0) ? int'($urandom_range(nl - 1)) : -1;
            bl  = ($urandom_range(1) == 0) ? int'($urandom_range(nl - 1)) : -1;
            sll = ($urandom_range(2) == 0) ? int'($urandom_range(nl - 1)) : -1;
            r   = $urandom;
            bv  = r[DW-1:0];
            if ($urandom_range(3) == 0) bv = PA;
            send_frame(nl, sl, bl, int'($urandom_range(L_LEN - 2)), bv,
                       sll, int'($urandom_range(L_LEN - 2)), -1, 1);
        end
        idle(6);
        check_state("b2b_rand");

        en = 1'b0;
        idle(2);
        check_eq("dis/locked", 32'(locked), 32'(0));
        send_frame(H_LEN, -1, 2, 3, '0, -1, -1, -1, 4);
        idle(4);
        check_state("dis");
        en = 1'b1;
        idle(4);

        send_frame(H_LEN, -1, -1, -1, '0, -1, -1, 12, 4);
        send_frame(H_LEN, -1, -1, -1, '0, -1, -1, -1, 4);
        idle(6);
        check_state("rst_resume");

        drive(1, 0, 0, '0);
        idle(3);
        exp_proto_err = 1;
        check_state("proto");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
